// File: rtl/key_filter_pkg.sv
// rtl/key_filter_pkg.sv - shared types and widths for the key debounce filter
package key_filter_pkg;

    localparam int CNT_W  = 24;
    localparam int HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_FILT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_FILT = 2'd3
    } kf_state_e;

endpackage

// File: rtl/key_filter_ch.sv
// rtl/key_filter_ch.sv - one debounced key channel: synchronizer, filter FSM, event pulses
// KEY_FILTER_REPEAT_EN selects auto-repeat of key_long while the key stays down.
module key_filter_ch
    import key_filter_pkg::*;
#(
    parameter logic [CNT_W-1:0]  CNT_MAX    = 24'd999_999,
    parameter logic [HOLD_W-1:0] HOLD_TICKS = 8'd50
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    logic              sync1_q, sync2_q;
    kf_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              cnt_done;
    logic [HOLD_W-1:0] hold_inc;

    assign cnt_done = (cnt_q == CNT_MAX);
    assign hold_inc = hold_q + HOLD_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= key_in;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    // sync2_q is the raw pin, still active-low: 0 means pressed
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = DOWN;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DOWN: begin
                if (sync2_q) begin
                    state_d = RELEASE_FILT;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    cnt_d = '0;
`ifdef KEY_FILTER_REPEAT_EN
                    if (hold_inc == HOLD_TICKS) begin
                        hold_d = '0;
                        long_d = 1'b1;
                    end else begin
                        hold_d = hold_inc;
                    end
`else
                    if (hold_q < HOLD_TICKS) begin
                        hold_d = hold_inc;
                        long_d = (hold_inc == HOLD_TICKS);
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE_FILT: begin
                if (!sync2_q) begin
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_state   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_filter.sv
// rtl/key_filter.sv - KEY_NUM independent debounced push-button channels
// KEY_FILTER_REPEAT_EN (in key_filter_ch) enables key_long auto-repeat.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int                KEY_NUM    = 4,
    parameter logic [CNT_W-1:0]  CNT_MAX    = 24'd999_999,
    parameter logic [HOLD_W-1:0] HOLD_TICKS = 8'd50
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_filter_ch #(
            .CNT_MAX    (CNT_MAX),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_ch (
            .sys_clk     (sys_clk),
            .sys_rst_n   (sys_rst_n),
            .key_in      (key_in[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_filter.sv
// tb/tb_key_filter.sv - directed and randomized checks of key_filter against a run-length model
module tb_key_filter;

    localparam int KN = 4;
    localparam int CM = 2;
    localparam int HT = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [KN-1:0] key_in;
    logic [KN-1:0] key_state, key_press, key_release, key_long;

    int checks   = 0;
    int failures = 0;

    // Reference: key is down once the synchronized pin has been low for CM+2
    // consecutive samples; every CM+1 further low samples in one stretch is a hold period.
    logic [KN-1:0] m_q1, m_q2, m_state, m_press, m_release, m_long;
    int run_lo[KN], run_hi[KN], since[KN], wraps[KN], dur[KN];
    int press_seen, release_seen;

    always #10 sys_clk = ~sys_clk;

    key_filter #(
        .KEY_NUM    (KN),
        .CNT_MAX    (24'd2),
        .HOLD_TICKS (8'd3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    task automatic model_reset();
        m_q1 = '1; m_q2 = '1;
        m_state = '0; m_press = '0; m_release = '0; m_long = '0;
        for (int k = 0; k < KN; k++) begin
            run_lo[k] = 0; run_hi[k] = 0; since[k] = 0; wraps[k] = 0;
        end
    endtask

    task automatic model_edge();
        logic s;
        for (int k = 0; k < KN; k++) begin
            s = m_q2[k];
            m_press[k] = 1'b0; m_release[k] = 1'b0; m_long[k] = 1'b0;
            if (!s) begin run_lo[k]++; run_hi[k] = 0; end
            else begin run_hi[k]++; run_lo[k] = 0; end
            if (!m_state[k]) begin
                if (run_lo[k] == CM + 2) begin
                    m_state[k] = 1'b1; m_press[k] = 1'b1; since[k] = 0; wraps[k] = 0;
                end
            end else if (!s) begin
                if (run_lo[k] == 1) begin
                    since[k] = 0;
                end else begin
                    since[k]++;
                    if (since[k] % (CM + 1) == 0) begin
                        wraps[k]++;
`ifdef KEY_FILTER_REPEAT_EN
                        if (wraps[k] % HT == 0) m_long[k] = 1'b1;
`else
                        if (wraps[k] == HT) m_long[k] = 1'b1;
`endif
                    end
                end
            end else if (run_hi[k] == CM + 2) begin
                m_state[k] = 1'b0; m_release[k] = 1'b1;
            end
        end
        m_q2 = m_q1;
        m_q1 = key_in;
    endtask

    task automatic check(input string tag, input logic [KN-1:0] obs, input logic [KN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("model_state", key_state, m_state);
        check("model_press", key_press, m_press);
        check("model_release", key_release, m_release);
        check("model_long", key_long, m_long);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        if (sys_rst_n) model_edge();
        else model_reset();
        #1;
        check_all();
        press_seen   += int'(key_press[0]) + int'(key_press[1]);
        release_seen += int'(key_release[0]);
    endtask

    initial begin
        key_in    = '1;
        sys_rst_n = 1'b0;
        press_seen = 0; release_seen = 0;
        model_reset();
        repeat (3) tick();
        check("reset_state", key_state, '0);
        check("reset_press", key_press, '0);
        sys_rst_n = 1'b1;
        repeat (3) tick();

        key_in = 4'b1110;
        repeat (5) tick();
        check("clean_press_early", key_press, '0);
        tick();
        check("clean_press", key_press, 4'b0001);
        check("clean_state", key_state, 4'b0001);
        repeat (2) tick();

        press_seen = 0; release_seen = 0;
        key_in[0] = 1'b1; repeat (2) tick();
        key_in[0] = 1'b0; tick();
        key_in[0] = 1'b1;
        repeat (12) tick();
        checks++;
        assert (release_seen == 1 && press_seen == 0) else begin
            failures++;
            $error("FAIL release_bounce observed=%0d/%0d expected=1/0", release_seen, press_seen);
        end

        key_in[1] = 1'b0; repeat (2) tick();
        key_in[1] = 1'b1; tick();
        key_in[1] = 1'b0;
        repeat (5) tick();
        check("bounce_press_early", key_press, '0);
        tick();
        check("bounce_press", key_press, 4'b0010);
        key_in = '1;
        repeat (8) tick();

        press_seen = 0;
        key_in[1] = 1'b0; repeat (3) tick();
        key_in[1] = 1'b1;
        repeat (10) tick();
        checks++;
        assert (press_seen == 0) else begin
            failures++;
            $error("FAIL glitch_press observed=%0d expected=0", press_seen);
        end

        key_in = 4'b1011;
        repeat (6) tick();
        check("long_press", key_press, 4'b0100);
        repeat (8) tick();
        check("long_early", key_long, '0);
        tick();
        check("long_fire", key_long, 4'b0100);
        repeat (9) tick();
`ifdef KEY_FILTER_REPEAT_EN
        check("long_repeat", key_long, 4'b0100);
`else
        check("long_once", key_long, '0);
`endif
        key_in = '1;
        repeat (8) tick();

        key_in = 4'b0110;
        repeat (6) tick();
        check("simul_press", key_press, 4'b1001);
        repeat (2) tick();

        key_in = 4'b0100;
        repeat (3) tick();
        #5;
        sys_rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("reset_async_state", key_state, '0);
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (5) tick();
        check("post_reset_early", key_press, '0);
        tick();
        check("post_reset_press", key_press, 4'b1011);
        key_in = '1;
        repeat (8) tick();

        for (int k = 0; k < KN; k++) dur[k] = $urandom_range(1, 10);
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < KN; k++) begin
                if (dur[k] == 0) begin
                    key_in[k] = ~key_in[k];
                    dur[k] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : $urandom_range(5, 25);
                end else begin
                    dur[k]--;
                end
            end
            if (i == 400) begin
                sys_rst_n = 1'b0;
                model_reset();
                tick();
                sys_rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
